// File: rtl/wdog_pkg.sv
// Shared constants for the watchdog: register map, key values, unlock ports
// and the key-sequence FSM state/mode encodings.
package wdog_pkg;

    localparam logic [3:0] ADDR_STATUS   = 4'h0;
    localparam logic [3:0] ADDR_LOAD     = 4'h1;
    localparam logic [3:0] ADDR_WARN     = 4'h2;
    localparam logic [3:0] ADDR_PRESC    = 4'h3;
    localparam logic [3:0] ADDR_WINDOW   = 4'h4;
    localparam logic [3:0] ADDR_COUNT    = 4'h5;
    localparam logic [3:0] ADDR_KEY      = 4'h8;
    localparam logic [3:0] ADDR_UNLOCK_A = 4'hA;
    localparam logic [3:0] ADDR_UNLOCK_K = 4'hE;

    localparam logic [7:0] KEY_01 = 8'h01;
    localparam logic [7:0] KEY_0F = 8'h0F;
    localparam logic [7:0] KEY_AA = 8'hAA;
    localparam logic [7:0] KEY_55 = 8'h55;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_STEP1 = 2'd1,
        SEQ_STEP2 = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_ENA  = 2'd0,
        MODE_DIS  = 2'd1,
        MODE_KICK = 2'd2
    } seq_mode_e;

endpackage

// File: rtl/wdog_key_fsm.sv
// Three-step key/unlock/key sequence checker. Emits one-cycle ena/dis/kick
// pulses in the cycle the final key write is presented.
module wdog_key_fsm
    import wdog_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write,
    input  logic       read,
    input  logic [3:0] addr,
    input  logic [7:0] key_data,
    input  logic       wdog_en,
    input  logic       timeout,
    output logic       ena_pulse,
    output logic       dis_pulse,
    output logic       kick_pulse,
    output logic [1:0] state_dbg
);

    seq_state_e state_q, state_d;
    seq_mode_e  mode_q, mode_d;
    logic       key_wr;

    assign key_wr    = write && (addr == ADDR_KEY);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            mode_q  <= MODE_ENA;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ena_pulse  = 1'b0;
        dis_pulse  = 1'b0;
        kick_pulse = 1'b0;
        // After expiry the watchdog can only be recovered by reset.
        if (timeout) begin
            state_d = SEQ_IDLE;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (key_wr) begin
                        if (key_data == KEY_01 && !wdog_en) begin
                            state_d = SEQ_STEP1;
                            mode_d  = MODE_ENA;
                        end else if (key_data == KEY_0F && wdog_en) begin
                            state_d = SEQ_STEP1;
                            mode_d  = MODE_DIS;
                        end else if (key_data == KEY_AA && wdog_en) begin
                            state_d = SEQ_STEP1;
                            mode_d  = MODE_KICK;
                        end
                    end
                end
                SEQ_STEP1: begin
                    // A simultaneous read and write counts as a write.
                    if (write) begin
                        state_d = SEQ_IDLE;
                    end else if (read) begin
                        if ((mode_q == MODE_KICK) ? (addr == ADDR_UNLOCK_K)
                                                  : (addr == ADDR_UNLOCK_A)) begin
                            state_d = SEQ_STEP2;
                        end else begin
                            state_d = SEQ_IDLE;
                        end
                    end
                end
                SEQ_STEP2: begin
                    if (write || read) begin
                        state_d = SEQ_IDLE;
                        if (key_wr) begin
                            case (mode_q)
                                MODE_ENA:  ena_pulse  = (key_data == KEY_0F);
                                MODE_DIS:  dis_pulse  = (key_data == KEY_01);
                                MODE_KICK: kick_pulse = (key_data == KEY_55);
                                default:   ;
                            endcase
                        end
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wdog_seq_timer.sv
// Windowed watchdog timer with prescaler, early-warning pulse and a
// key-sequence protected enable/disable/kick interface.
module wdog_seq_timer
    import wdog_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              wdog_en,
    output logic              warn,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [CNT_W-1:0]  load_q, load_d, warn_val_q, warn_val_d;
    logic [CNT_W-1:0]  window_q, window_d, count_q, count_d, count_dec;
    logic [PRE_W-1:0]  presc_q, presc_d, pre_q, pre_d;
    logic              wdog_en_q, wdog_en_d, timeout_q, timeout_d;
    logic              wfault_q, wfault_d, warn_q, warn_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ena_pulse, dis_pulse, kick_pulse, tick, cfg_wr;
    logic [1:0]        fsm_state;
    logic              wdata_unused;

    wdog_key_fsm u_key_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .read       (read),
        .addr       (addr),
        .key_data   (wdata[7:0]),
        .wdog_en    (wdog_en_q),
        .timeout    (timeout_q),
        .ena_pulse  (ena_pulse),
        .dis_pulse  (dis_pulse),
        .kick_pulse (kick_pulse),
        .state_dbg  (fsm_state)
    );

    assign tick         = (pre_q == presc_q);
    assign count_dec    = count_q - CNT_ONE;
    assign cfg_wr       = write && !wdog_en_q;
    assign wdata_unused = ^wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q     <= '1;
            warn_val_q <= '0;
            presc_q    <= '0;
            window_q   <= '0;
            count_q    <= '0;
            pre_q      <= '0;
            wdog_en_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wfault_q   <= 1'b0;
            warn_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            load_q     <= load_d;
            warn_val_q <= warn_val_d;
            presc_q    <= presc_d;
            window_q   <= window_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            wdog_en_q  <= wdog_en_d;
            timeout_q  <= timeout_d;
            wfault_q   <= wfault_d;
            warn_q     <= warn_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        load_d     = load_q;
        warn_val_d = warn_val_q;
        presc_d    = presc_q;
        window_d   = window_q;
        count_d    = count_q;
        pre_d      = pre_q;
        wdog_en_d  = wdog_en_q;
        timeout_d  = timeout_q;
        wfault_d   = wfault_q;
        warn_d     = 1'b0;
        rdata_d    = '0;

        if (cfg_wr) begin
            case (addr)
                ADDR_LOAD:   load_d     = wdata[CNT_W-1:0];
                ADDR_WARN:   warn_val_d = wdata[CNT_W-1:0];
                ADDR_PRESC:  presc_d    = wdata[PRE_W-1:0];
                ADDR_WINDOW: window_d   = wdata[CNT_W-1:0];
                default:     ;
            endcase
        end

        // Counter freezes once expired; kick has priority over a same-cycle expiry.
        if (ena_pulse) begin
            wdog_en_d = 1'b1;
            count_d   = load_q;
            pre_d     = '0;
        end else if (dis_pulse) begin
            wdog_en_d = 1'b0;
        end else if (wdog_en_q && !timeout_q) begin
            if (kick_pulse) begin
                if (window_q != '0 && count_q > window_q) begin
                    wfault_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    count_d = load_q;
                    pre_d   = '0;
                end
            end else begin
                pre_d = tick ? '0 : pre_q + PRE_ONE;
                if (tick) begin
                    if (count_q <= CNT_ONE) timeout_d = 1'b1;
                    if (count_q != '0) begin
                        count_d = count_dec;
                        warn_d  = (count_dec == warn_val_q);
                    end
                end
            end
        end

        if (read && !write) begin
            case (addr)
                ADDR_STATUS: rdata_d = DATA_W'({fsm_state, wfault_q, timeout_q, wdog_en_q});
                ADDR_LOAD:   rdata_d = DATA_W'(load_q);
                ADDR_WARN:   rdata_d = DATA_W'(warn_val_q);
                ADDR_PRESC:  rdata_d = DATA_W'(presc_q);
                ADDR_WINDOW: rdata_d = DATA_W'(window_q);
                ADDR_COUNT:  rdata_d = DATA_W'(count_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign wdog_en = wdog_en_q;
    assign warn    = warn_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_wdog_seq_timer.sv
// Bench for wdog_seq_timer: register/sequence vector table followed by
// timed multi-cycle scenarios for expiry, warning, window and reset.
module tb_wdog_seq_timer;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic        read;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wdog_en;
    logic        warn;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    wdog_seq_timer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .write   (write),
        .read    (read),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .wdog_en (wdog_en),
        .warn    (warn),
        .timeout (timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // drivers
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        write = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        read = 1'b1;
        addr = a;
        @(negedge clk);
        read = 1'b0;
        check(name, rdata, exp_q.pop_front());
    endtask

    task automatic seq_enable();
        bus_write(4'h8, 32'h01);
        bus_read(4'hA, 32'h0, "unlock_a_rd");
        bus_write(4'h8, 32'h0F);
    endtask

    task automatic seq_disable();
        bus_write(4'h8, 32'h0F);
        bus_read(4'hA, 32'h0, "unlock_a_rd");
        bus_write(4'h8, 32'h01);
    endtask

    task automatic seq_kick();
        bus_write(4'h8, 32'hAA);
        bus_read(4'hE, 32'h0, "unlock_e_rd");
        bus_write(4'h8, 32'h55);
    endtask

    function automatic void add_vec(input bit wr, input logic [3:0] a,
                                    input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.wr   = wr;
        v.addr = a;
        v.data = d;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    initial begin
        int warn_cnt;
        int warn_at;
        int to_at;

        write = 1'b0;
        read  = 1'b0;
        addr  = 4'h0;
        wdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wdog_en", wdog_en, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_warn", warn, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // register map and single-step sequence behaviour while disabled
        add_vec(0, 4'h0, 0, 32'h0);
        add_vec(0, 4'h1, 0, 32'hFFFF);
        add_vec(0, 4'h2, 0, 32'h0);
        add_vec(0, 4'h3, 0, 32'h0);
        add_vec(0, 4'h4, 0, 32'h0);
        add_vec(0, 4'h5, 0, 32'h0);
        add_vec(1, 4'h1, 32'd10, 0);
        add_vec(0, 4'h1, 0, 32'd10);
        add_vec(1, 4'h3, 32'h1FF, 0);
        add_vec(0, 4'h3, 0, 32'hFF);
        add_vec(1, 4'h3, 32'h0, 0);
        add_vec(0, 4'h3, 0, 32'h0);
        add_vec(1, 4'h6, 32'h1234, 0);
        add_vec(0, 4'h6, 0, 32'h0);
        add_vec(0, 4'hA, 0, 32'h0);
        add_vec(0, 4'h8, 0, 32'h0);
        add_vec(1, 4'h8, 32'h01, 0);
        add_vec(0, 4'h0, 0, 32'h08);
        add_vec(0, 4'h0, 0, 32'h00);
        add_vec(1, 4'h8, 32'h0F, 0);
        add_vec(0, 4'h0, 0, 32'h00);
        add_vec(1, 4'h8, 32'hAA, 0);
        add_vec(0, 4'h0, 0, 32'h00);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // LOAD=10, PRESC=0: expiry exactly 10 cycles after enable
        seq_enable();
        check("ena_wdog_en", wdog_en, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("expire_t%0d", i), timeout, (i == 10));
        end
        bus_read(4'h0, 32'h03, "expire_status");
        bus_read(4'h5, 32'h0, "expire_count");

        // aborted kick leaves LOAD alone and the count keeps running
        apply_reset();
        bus_write(4'h1, 32'd100);
        seq_enable();
        bus_write(4'h8, 32'hAA);
        bus_write(4'h1, 32'd5);
        bus_write(4'h8, 32'h55);
        bus_read(4'h1, 32'd100, "abort_load");
        bus_read(4'h5, 32'd96, "abort_count");
        bus_read(4'h0, 32'h01, "abort_status");
        seq_kick();
        bus_read(4'h5, 32'd100, "kick_reload");
        seq_disable();
        check("dis_wdog_en", wdog_en, 1'b0);
        bus_read(4'h5, 32'd97, "dis_count0");
        idle(5);
        bus_read(4'h5, 32'd97, "dis_count1");

        // warning pulse and prescaled expiry
        apply_reset();
        bus_write(4'h1, 32'd100);
        bus_write(4'h3, 32'd3);
        bus_write(4'h2, 32'd5);
        seq_enable();
        warn_cnt = 0;
        warn_at  = -1;
        to_at    = -1;
        for (int i = 1; i <= 420; i++) begin
            @(negedge clk);
            if (warn) begin
                warn_cnt++;
                warn_at = i;
            end
            if (timeout && to_at < 0) to_at = i;
        end
        check("warn_pulses", warn_cnt, 1);
        check("warn_cycle", warn_at, 380);
        check("presc_timeout_cycle", to_at, 400);

        // window: early kick at 80 faults, kick at 40 reloads
        apply_reset();
        bus_write(4'h4, 32'd50);
        bus_write(4'h1, 32'd100);
        seq_enable();
        idle(58);
        seq_kick();
        check("win_ok_timeout", timeout, 1'b0);
        bus_read(4'h5, 32'd100, "win_ok_count");
        idle(17);
        seq_kick();
        check("win_fault_timeout", timeout, 1'b1);
        bus_read(4'h0, 32'h07, "win_fault_status");
        bus_write(4'h8, 32'h0F);
        bus_read(4'h0, 32'h07, "locked_status");

        // kick on the cycle the count would reach zero
        apply_reset();
        bus_write(4'h1, 32'd20);
        seq_enable();
        idle(17);
        seq_kick();
        check("last_kick_timeout", timeout, 1'b0);
        bus_read(4'h5, 32'd20, "last_kick_count");

        // reset asserted while in STEP2
        bus_write(4'h8, 32'hAA);
        bus_read(4'hE, 32'h0, "step2_unlock");
        rst_n = 1'b0;
        #1;
        check("midseq_wdog_en", wdog_en, 1'b0);
        check("midseq_timeout", timeout, 1'b0);
        check("midseq_warn", warn, 1'b0);
        check("midseq_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(4'h0, 32'h0, "post_rst_status");
        bus_write(4'h8, 32'h55);
        bus_read(4'h0, 32'h0, "post_rst_key55");

        // LOAD=0 expires on the first prescaler wrap
        apply_reset();
        bus_write(4'h1, 32'd0);
        bus_write(4'h3, 32'd2);
        seq_enable();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("load0_t%0d", i), timeout, (i == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
